// File: rtl/isect_scan_sched_if.sv
// isect_scan_sched_if: ray, triangle RAM, intersection unit and result signals of the scan scheduler
interface isect_scan_sched_if #(parameter int IDX_W = 16);
  logic             i_ray_valid;
  logic             o_ray_ready;
  logic [191:0]     i_ray;
  logic [IDX_W-1:0] i_tri_base;
  logic [IDX_W-1:0] i_num_tri;
  logic             o_mem_rd;
  logic [IDX_W-1:0] o_mem_addr;
  logic [287:0]     i_mem_rdata;
  logic             o_isect_en;
  logic [287:0]     o_isect_tri;
  logic [191:0]     o_isect_ray;
  logic             i_isect_valid;
  logic             i_isect_result;
  logic [31:0]      i_isect_t;
  logic             o_hit_valid;
  logic             i_hit_ready;
  logic             o_hit;
  logic [31:0]      o_hit_t;
  logic [IDX_W-1:0] o_hit_idx;
  logic [31:0]      o_busy_cycles;
  modport slave (
    input  i_ray_valid, i_ray, i_tri_base, i_num_tri, i_mem_rdata,
           i_isect_valid, i_isect_result, i_isect_t, i_hit_ready,
    output o_ray_ready, o_mem_rd, o_mem_addr, o_isect_en, o_isect_tri,
           o_isect_ray, o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_busy_cycles
  );
  modport master (
    output i_ray_valid, i_ray, i_tri_base, i_num_tri, i_mem_rdata,
           i_isect_valid, i_isect_result, i_isect_t, i_hit_ready,
    input  o_ray_ready, o_mem_rd, o_mem_addr, o_isect_en, o_isect_tri,
           o_isect_ray, o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_busy_cycles
  );
endinterface

// File: rtl/isect_scan_sched.sv
// isect_scan_sched: per-ray triangle scan scheduler, closest-hit reduction; ISECT_SCHED_PERF_EN adds busy-cycle counter
module isect_scan_sched #(
  parameter int               IDX_W = 16,
  parameter logic signed [31:0] MAX_T = 32'sh7fffffff
) (
  input logic i_clk,
  input logic i_rst,
  isect_scan_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t             state, state_nx;
  logic [191:0]       ray;
  logic [IDX_W-1:0]   base, num, issue_cnt, ret_cnt, best_idx;
  logic signed [31:0] best_t;
  logic               hit, isect_en, accept, scanning, ret_fire, better;
  assign accept   = state == IDLE && bus.i_ray_valid;
  assign scanning = state == ISSUE || state == DRAIN;
  // results past the requested count are dropped so they cannot disturb the reduction
  assign ret_fire = bus.i_isect_valid && scanning && ret_cnt != num;
  assign better   = ret_fire && bus.i_isect_result && $signed(bus.i_isect_t) < best_t;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = accept ? (bus.i_num_tri == '0 ? DONE : ISSUE) : IDLE;
      ISSUE: state_nx = issue_cnt == num - IDX_W'(1) ? DRAIN : ISSUE;
      DRAIN: state_nx = ret_cnt + IDX_W'(ret_fire) == num ? DONE : DRAIN;
      DONE:  state_nx = bus.i_hit_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      isect_en  <= 1'b0;
      ray       <= '0;
      base      <= '0;
      num       <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      best_t    <= MAX_T;
      best_idx  <= '0;
      hit       <= 1'b0;
    end else begin
      state    <= state_nx;
      isect_en <= state == ISSUE;
      if (accept) begin
        ray       <= bus.i_ray;
        base      <= bus.i_tri_base;
        num       <= bus.i_num_tri;
        issue_cnt <= '0;
        ret_cnt   <= '0;
        best_t    <= MAX_T;
        best_idx  <= '0;
        hit       <= 1'b0;
      end
      if (state == ISSUE) issue_cnt <= issue_cnt + IDX_W'(1);
      if (ret_fire) ret_cnt <= ret_cnt + IDX_W'(1);
      if (better) begin
        best_t   <= $signed(bus.i_isect_t);
        best_idx <= ret_cnt;
        hit      <= 1'b1;
      end
    end
  end
  assign bus.o_ray_ready = state == IDLE;
  assign bus.o_mem_rd    = state == ISSUE;
  assign bus.o_mem_addr  = base + issue_cnt;
  assign bus.o_isect_en  = isect_en;
  assign bus.o_isect_tri = bus.i_mem_rdata;
  assign bus.o_isect_ray = ray;
  assign bus.o_hit_valid = state == DONE;
  assign bus.o_hit       = hit;
  assign bus.o_hit_t     = best_t;
  assign bus.o_hit_idx   = best_idx;
`ifdef ISECT_SCHED_PERF_EN
  logic [31:0] busy;
  always_ff @(posedge i_clk) begin
    if (i_rst || accept) busy <= '0;
    else if (scanning && busy != '1) busy <= busy + 32'd1;
  end
  assign bus.o_busy_cycles = busy;
`else
  assign bus.o_busy_cycles = '0;
`endif
endmodule

// File: tb/tb_isect_scan_sched.sv
// tb_isect_scan_sched: directed checks of scan scheduler with a 3-cycle intersection unit model
module tb_isect_scan_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_fail = 0;
  int   lat;
  isect_scan_sched_if #(.IDX_W(16)) bus();
  isect_scan_sched dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [2:0]  pipe = '0;
  logic [2:0]  k = '0;
  logic        hit_tab [8];
  logic [31:0] t_tab [8];
  logic [15:0] addr_log[$], tri_log[$];
  int          rd_cnt = 0, en_cnt = 0;
  assign bus.i_isect_valid  = pipe[2];
  assign bus.i_isect_result = hit_tab[k];
  assign bus.i_isect_t      = t_tab[k];
  always @(posedge clk) begin
    pipe <= {pipe[1:0], bus.o_isect_en};
    bus.i_mem_rdata <= {272'h0, bus.o_mem_addr};
    if (bus.i_ray_valid && bus.o_ray_ready && !rst) begin
      k <= '0;
      rd_cnt <= 0;
      en_cnt <= 0;
      addr_log.delete();
      tri_log.delete();
    end else begin
      if (pipe[2]) k <= k + 3'd1;
      if (bus.o_mem_rd) begin
        rd_cnt <= rd_cnt + 1;
        addr_log.push_back(bus.o_mem_addr);
      end
      if (bus.o_isect_en) begin
        en_cnt <= en_cnt + 1;
        tri_log.push_back(bus.o_isect_tri[15:0]);
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int l);
    l = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_ray_valid = 1'b0;
      if (bus.o_hit_valid) begin
        l = c;
        break;
      end
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.o_ray_ready, 1);
    chk({tag, "_rd"}, bus.o_mem_rd, 0);
    chk({tag, "_en"}, bus.o_isect_en, 0);
    chk({tag, "_hv"}, bus.o_hit_valid, 0);
    chk({tag, "_hit"}, bus.o_hit, 0);
    chk({tag, "_t"}, bus.o_hit_t, 32'h7fffffff);
    chk({tag, "_idx"}, bus.o_hit_idx, 0);
    chk({tag, "_busy"}, bus.o_busy_cycles, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_ray_valid = 1'b0;
    bus.i_ray = '0;
    bus.i_tri_base = '0;
    bus.i_num_tri = '0;
    bus.i_hit_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit_tab[i] = 1'b0;
      t_tab[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    // four hits with a tie at t=1.5: lower index must win
    hit_tab[0] = 1; t_tab[0] = 32'h00030000;
    hit_tab[1] = 1; t_tab[1] = 32'h00018000;
    hit_tab[2] = 1; t_tab[2] = 32'h00020000;
    hit_tab[3] = 1; t_tab[3] = 32'h00018000;
    bus.i_ray = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    bus.i_tri_base = 16'd10;
    bus.i_num_tri = 16'd4;
    bus.i_ray_valid = 1'b1;
    wait_done(lat);
    bus.i_ray = '1;
    chk("t1_latency", lat, 9);
    chk("t1_nrd", addr_log.size(), 4);
    chk("t1_addr0", addr_log[0], 10);
    chk("t1_addr3", addr_log[3], 13);
    chk("t1_tri1", tri_log[1], 11);
    chk("t1_tri3", tri_log[3], 13);
    chk("t1_ray", bus.o_isect_ray[63:0], {32'h5, 32'h6});
    chk("t1_hit", bus.o_hit, 1);
    chk("t1_t", bus.o_hit_t, 32'h00018000);
    chk("t1_idx", bus.o_hit_idx, 1);
`ifdef ISECT_SCHED_PERF_EN
    chk("t1_busy", bus.o_busy_cycles, 8);
`else
    chk("t1_busy", bus.o_busy_cycles, 0);
`endif
    // hold DONE with a pending ray; the pending ray is the all-miss scan wrapping the address
    for (int i = 0; i < 8; i++) hit_tab[i] = 1'b0;
    bus.i_tri_base = 16'hfffe;
    bus.i_num_tri = 16'd3;
    bus.i_ray_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_hv", bus.o_hit_valid, 1);
      chk("hold_ready", bus.o_ray_ready, 0);
      chk("hold_t", bus.o_hit_t, 32'h00018000);
      chk("hold_idx", bus.o_hit_idx, 1);
    end
    bus.i_hit_ready = 1'b1;
    @(negedge clk);
    bus.i_hit_ready = 1'b0;
    chk("hs_hv", bus.o_hit_valid, 0);
    chk("hs_ready", bus.o_ray_ready, 1);
    wait_done(lat);
    chk("t2_latency", lat, 8);
    chk("t2_nrd", addr_log.size(), 3);
    chk("t2_addr1", addr_log[1], 16'hffff);
    chk("t2_addr2", addr_log[2], 16'h0000);
    chk("t2_hit", bus.o_hit, 0);
    chk("t2_t", bus.o_hit_t, 32'h7fffffff);
    chk("t2_idx", bus.o_hit_idx, 0);
    bus.i_hit_ready = 1'b1;
    @(negedge clk);
    bus.i_hit_ready = 1'b0;
    // empty scan
    bus.i_num_tri = 16'd0;
    bus.i_ray_valid = 1'b1;
    wait_done(lat);
    chk("t3_latency", lat, 1);
    chk("t3_nrd", rd_cnt, 0);
    chk("t3_nen", en_cnt, 0);
    chk("t3_hit", bus.o_hit, 0);
    bus.i_hit_ready = 1'b1;
    @(negedge clk);
    bus.i_hit_ready = 1'b0;
    // reset during ISSUE after three reads
    for (int i = 0; i < 8; i++) begin
      hit_tab[i] = 1'b1;
      t_tab[i] = 32'h00010000;
    end
    bus.i_tri_base = 16'd0;
    bus.i_num_tri = 16'd8;
    bus.i_ray_valid = 1'b1;
    @(negedge clk);
    bus.i_ray_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rd", bus.o_mem_rd, 1);
    chk("mid_en", bus.o_isect_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("stale_hv", bus.o_hit_valid, 0);
    chk("stale_hit", bus.o_hit, 0);
    chk("stale_ready", bus.o_ray_ready, 1);
    hit_tab[0] = 1'b1;
    t_tab[0] = 32'h00008000;
    bus.i_num_tri = 16'd1;
    bus.i_ray_valid = 1'b1;
    wait_done(lat);
    chk("t5_latency", lat, 6);
    chk("t5_hit", bus.o_hit, 1);
    chk("t5_t", bus.o_hit_t, 32'h00008000);
    chk("t5_idx", bus.o_hit_idx, 0);
`ifdef ISECT_SCHED_PERF_EN
    chk("t5_busy", bus.o_busy_cycles, 5);
`else
    chk("t5_busy", bus.o_busy_cycles, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
